// File: rtl/rotate_detect_32_if.sv
// Handshake and data bundle for rotate_detect_32.
//   start  : request a search (sampled only while idle)
//   D, R   : original and rotated words, captured on accepted start
//   LorR   : search direction, 0 = left, 1 = right
//   busy   : search in progress (any state other than idle)
//   done   : one-cycle completion pulse
//   found  : last search matched; held until the next completion
//   amount : smallest matching rotation amount; held until the next completion
interface rotate_detect_32_if;
   logic        start;
   logic [31:0] D;
   logic [31:0] R;
   logic        LorR;
   logic        busy;
   logic        done;
   logic        found;
   logic [4:0]  amount;

   modport master (
      output start, D, R, LorR,
      input  busy, done, found, amount
   );

   modport slave (
      input  start, D, R, LorR,
      output busy, done, found, amount
   );
endinterface

// File: rtl/rotate_detect_32.sv
// rotate_detect_32: sequential inverse of the 32-bit rotator. Searches the
// rotation amount (0-31) in the requested direction that maps D onto R,
// testing one amount per cycle and reporting the smallest match.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : rotate_detect_32_if slave (start/D/R/LorR in; busy/done/found/amount out)
module rotate_detect_32 (
   input  logic              clk,
   input  logic              reset,
   rotate_detect_32_if.slave bus
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned AMT_W  = 5;
   localparam logic [AMT_W-1:0] CNT_LAST = AMT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_w;
   logic [DATA_W-1:0] r_t;
   logic              r_dir;
   logic [AMT_W-1:0]  r_cnt;
   logic              r_busy;
   logic              r_done;
   logic              r_found;
   logic [AMT_W-1:0]  r_amount;

   logic [DATA_W-1:0] w_rot1;
   logic              w_match;

   // Single-step rotation of the work word in the captured direction
   assign w_rot1  = r_dir ? {r_w[0], r_w[DATA_W-1:1]}
                          : {r_w[DATA_W-2:0], r_w[DATA_W-1]};
   assign w_match = (r_w == r_t);

   // Search controller; busy/done are registered alongside the state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_w      <= '0;
         r_t      <= '0;
         r_dir    <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_found  <= 1'b0;
         r_amount <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_w     <= bus.D;
                  r_t     <= bus.R;
                  r_dir   <= bus.LorR;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SEARCH;
               end
            end
            ST_SEARCH: begin
               // Match is checked before the exhaustion limit so that a
               // match at amount 31 is still reported as found.
               if (w_match) begin
                  r_amount <= r_cnt;
                  r_found  <= 1'b1;
                  r_done   <= 1'b1;
                  r_state  <= ST_DONE;
               end else if (r_cnt == CNT_LAST) begin
                  r_amount <= '0;
                  r_found  <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= ST_DONE;
               end else begin
                  r_w   <= w_rot1;
                  r_cnt <= r_cnt + AMT_W'(1);
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.found  = r_found;
   assign bus.amount = r_amount;

endmodule

// File: tb/tb_rotate_detect_32.sv
// Self-checking bench for rotate_detect_32 with a behavioural reference model.
module tb_rotate_detect_32;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   rotate_detect_32_if u_if ();

   rotate_detect_32 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rotation by k computed with plain shifts
   function automatic logic [31:0] rot(input logic [31:0] d, input int k, input logic dir);
      int s;
      s = dir ? (32 - k) % 32 : k % 32;
      if (s == 0) return d;
      return (d << s) | (d >> (32 - s));
   endfunction

   // Reference: smallest k with rot(D,k)==R, plus expected latency
   function automatic void model(input logic [31:0] d, input logic [31:0] r, input logic dir,
                                 output logic f, output logic [4:0] a, output int lat);
      f = 1'b0;
      a = 5'd0;
      for (int k = 31; k >= 0; k--)
         if (rot(d, k, dir) == r) begin
            f = 1'b1;
            a = 5'(k);
         end
      lat = f ? int'(a) + 1 : 32;
   endfunction

   // Start a search and wait (bounded) for done; returns observed results
   task automatic do_search(input logic [31:0] d, input logic [31:0] r, input logic dir,
                            output int lat, output logic b0, output logic f,
                            output logic [4:0] a);
      @(negedge clk);
      u_if.start = 1'b1;
      u_if.D     = d;
      u_if.R     = r;
      u_if.LorR  = dir;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      u_if.D     = $urandom;
      u_if.R     = $urandom;
      u_if.LorR  = 1'($urandom);
      b0  = u_if.busy;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (u_if.done) break;
      end
      f = u_if.found;
      a = u_if.amount;
   endtask

   // After a completion: next cycle must be idle with done low
   task automatic check_tail(input string name);
      @(posedge clk);
      #1;
      checks++;
      if (u_if.done !== 1'b0 || u_if.busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_tail: done=%b busy=%b, required done=0 busy=0", name, u_if.done, u_if.busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      u_if.start = 1'b0;
      u_if.D = '0;
      u_if.R = '0;
      u_if.LorR = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({u_if.busy, u_if.done, u_if.found, u_if.amount} !== 8'h00) begin
         failures++;
         $display("FAIL reset_values: busy=%b done=%b found=%b amount=%0d, required all 0",
                  u_if.busy, u_if.done, u_if.found, u_if.amount);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Directed case with constant expectations
   task automatic run_directed(input string name, input logic [31:0] d, input logic [31:0] r,
                               input logic dir, input logic ef, input logic [4:0] ea, input int elat);
      int lat;
      logic b0, f;
      logic [4:0] a;
      do_search(d, r, dir, lat, b0, f, a);
      checks++;
      if (b0 !== 1'b1) begin
         failures++;
         $display("FAIL %s_busy: busy=%b, required 1", name, b0);
      end
      checks++;
      if (lat !== elat || f !== ef || a !== ea) begin
         failures++;
         $display("FAIL %s: latency=%0d found=%b amount=%0d, required latency=%0d found=%b amount=%0d",
                  name, lat, f, a, elat, ef, ea);
      end
      check_tail(name);
   endtask

   task automatic test_directed();
      run_directed("left4",    32'h12345678, 32'h23456781, 1'b0, 1'b1, 5'd4,  5);
      run_directed("right28",  32'h12345678, 32'h23456781, 1'b1, 1'b1, 5'd28, 29);
      run_directed("identity", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 5'd0,  1);
      run_directed("periodic", 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1, 5'd1,  2);
      run_directed("nomatch",  32'h00000001, 32'h00000003, 1'b0, 1'b0, 5'd0,  32);
      run_directed("restart",  32'h00000001, 32'h80000000, 1'b1, 1'b1, 5'd1,  2);
      run_directed("left31",   32'h00000001, 32'h80000000, 1'b0, 1'b1, 5'd31, 32);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         logic [31:0] d, r;
         logic dir, ef, f, b0;
         logic [4:0] ea, a;
         int elat, lat;
         d   = $urandom;
         dir = 1'($urandom);
         if (i % 4 == 3) r = $urandom;
         else if (i % 8 == 5) begin
            d = {4{8'($urandom)}};
            r = rot(d, int'($urandom_range(0, 31)), 1'($urandom));
         end else r = rot(d, int'($urandom_range(0, 31)), 1'($urandom));
         model(d, r, dir, ef, ea, elat);
         do_search(d, r, dir, lat, b0, f, a);
         checks++;
         if (lat !== elat || f !== ef || a !== ea) begin
            failures++;
            $display("FAIL random_%0d: D=%h R=%h dir=%b latency=%0d found=%b amount=%0d, required latency=%0d found=%b amount=%0d",
                     i, d, r, dir, lat, f, a, elat, ef, ea);
         end
         check_tail("random");
      end
   endtask

   // start pulsed mid-search is ignored; start on the idle cycle after done is accepted
   task automatic test_back_to_back();
      int lat;
      logic f;
      logic [4:0] a;
      @(negedge clk);
      u_if.start = 1'b1;
      u_if.D = 32'h12345678;
      u_if.R = rot(32'h12345678, 10, 1'b0);
      u_if.LorR = 1'b0;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      u_if.start = 1'b1;
      u_if.D = 32'hDEADBEEF;
      u_if.R = 32'hDEADBEEF;
      u_if.LorR = 1'b1;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      lat = 4;
      while (lat < 40 && !u_if.done) begin
         @(posedge clk);
         #1;
         lat++;
      end
      f = u_if.found;
      a = u_if.amount;
      checks++;
      if (lat !== 11 || f !== 1'b1 || a !== 5'd10) begin
         failures++;
         $display("FAIL ignore_busy_start: latency=%0d found=%b amount=%0d, required latency=11 found=1 amount=10",
                  lat, f, a);
      end
      // DONE -> IDLE edge, then present start during the idle cycle
      @(posedge clk);
      #1;
      u_if.start = 1'b1;
      u_if.D = 32'h0000F000;
      u_if.R = 32'h000F0000;
      u_if.LorR = 1'b0;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      checks++;
      if (u_if.busy !== 1'b1) begin
         failures++;
         $display("FAIL idle_restart_accept: busy=%b, required 1", u_if.busy);
      end
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (u_if.done) break;
      end
      checks++;
      if (lat !== 5 || u_if.found !== 1'b1 || u_if.amount !== 5'd4) begin
         failures++;
         $display("FAIL idle_restart: latency=%0d found=%b amount=%0d, required latency=5 found=1 amount=4",
                  lat, u_if.found, u_if.amount);
      end
      check_tail("idle_restart");
   endtask

   // Asynchronous reset mid-search aborts without a done pulse
   task automatic test_reset_abort();
      int seen;
      @(negedge clk);
      u_if.start = 1'b1;
      u_if.D = 32'h12345678;
      u_if.R = rot(32'h12345678, 20, 1'b0);
      u_if.LorR = 1'b0;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if ({u_if.busy, u_if.done, u_if.found, u_if.amount} !== 8'h00) begin
         failures++;
         $display("FAIL reset_abort: busy=%b done=%b found=%b amount=%0d, required all 0",
                  u_if.busy, u_if.done, u_if.found, u_if.amount);
      end
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (u_if.done || u_if.busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL reset_no_done: active cycles=%0d, required 0", seen);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
